// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master scheduler: transfer modes, FSM states and
// the per-requester descriptor layout.
package spi_pkg;

  localparam logic [1:0] MODE_RD     = 2'b00;
  localparam logic [1:0] MODE_WR     = 2'b01;
  localparam logic [1:0] MODE_CMD_RD = 2'b10;
  localparam logic [1:0] MODE_BAD    = 2'b11;

  localparam int unsigned CfgModeLsb     = 0;
  localparam int unsigned CfgCpolBit     = 2;
  localparam int unsigned CfgCphaBit     = 3;
  localparam int unsigned CfgWrWidthLsb  = 4;
  localparam int unsigned CfgRdWidthLsb  = 10;
  localparam int unsigned CfgRdTargetLsb = 16;

  typedef enum logic [2:0] {
    StIdle,
    StConfig,
    StStart,
    StRun,
    StRelease
  } sched_state_e;

  typedef struct packed {
    logic [15:0] rd_target_num;
    logic [5:0]  rd_width;
    logic [5:0]  wr_width;
    logic        cpha;
    logic        cpol;
    logic [1:0]  w_r_mode;
  } spi_cfg_t;

  // Write mode on an idle bus keeps the master's rx sampling counters cleared.
  localparam spi_cfg_t CfgPark = '{
    rd_target_num: 16'd0,
    rd_width:      6'd0,
    wr_width:      6'd0,
    cpha:          1'b0,
    cpol:          1'b0,
    w_r_mode:      MODE_WR
  };

  function automatic spi_cfg_t cfg_decode(input logic [31:0] word);
    spi_cfg_t c;
    c.w_r_mode      = word[CfgModeLsb +: 2];
    c.cpol          = word[CfgCpolBit];
    c.cpha          = word[CfgCphaBit];
    c.wr_width      = word[CfgWrWidthLsb +: 6];
    c.rd_width      = word[CfgRdWidthLsb +: 6];
    c.rd_target_num = word[CfgRdTargetLsb +: 16];
    return c;
  endfunction

  function automatic logic mode_reads(input logic [1:0] mode);
    return (mode == MODE_RD) || (mode == MODE_CMD_RD);
  endfunction

endpackage

// File: rtl/spi_master_sched_if.sv
// Bus between the scheduler and the shared SPI master: configuration, start/done strobes
// and the AXI-stream read-word channel.
interface spi_master_sched_if;
  logic        spi_cpol;
  logic        spi_cpha;
  logic [1:0]  spi_w_r_mode;
  logic [5:0]  spi_wr_width;
  logic [5:0]  spi_rd_width;
  logic [15:0] spi_rd_target_num;
  logic        spi_start;
  logic        spi_done;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;

  modport master (
    output spi_cpol, spi_cpha, spi_w_r_mode, spi_wr_width, spi_rd_width, spi_rd_target_num,
    output spi_start, s_axis_tready,
    input  spi_done, s_axis_tdata, s_axis_tvalid
  );

  modport slave (
    input  spi_cpol, spi_cpha, spi_w_r_mode, spi_wr_width, spi_rd_width, spi_rd_target_num,
    input  spi_start, s_axis_tready,
    output spi_done, s_axis_tdata, s_axis_tvalid
  );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: searches upward from the requester after last_grant_i.
module spi_rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_grant_i,
  output logic [IdxW-1:0]   gnt_id_o,
  output logic              gnt_any_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    idx       = '0;
    gnt_id_o  = '0;
    gnt_any_o = 1'b0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      idx = IdxW'((32'(last_grant_i) + k) % NumReq);
      if (!gnt_any_o && req_i[idx]) begin
        gnt_any_o = 1'b1;
        gnt_id_o  = idx;
      end
    end
  end

endmodule

// File: rtl/spi_master_sched.sv
// Shares one SPI master between NUM_REQ requesters: round-robin grant, config drive, start
// strobe, read-word routing and release. Optional RUN watchdog: SPI_SCHED_TIMEOUT_EN.
module spi_master_sched
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_cfg,
  spi_master_sched_if.master     spi,
  output logic [31:0]            rd_tdata,
  output logic [NUM_REQ-1:0]     rd_tvalid,
  input  logic [NUM_REQ-1:0]     rd_tready,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic [NUM_REQ-1:0]     err
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e      state_q;
  spi_cfg_t          out_q;
  spi_cfg_t          pick_cfg;
  logic [IdxW-1:0]   grant_q, last_q, pick_id;
  logic              pick_any;
  logic              busy_q, start_q, done_seen_q;
  logic [NUM_REQ-1:0] ready_q, err_q;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic              accept_en, hs, complete;

  // A requester whose accept pulse is still visible has not dropped valid yet.
  spi_rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_arb (
    .req_i        (req_valid & ~ready_q),
    .last_grant_i (last_q),
    .gnt_id_o     (pick_id),
    .gnt_any_o    (pick_any)
  );

  assign pick_cfg = cfg_decode(req_cfg[32*int'(pick_id) +: 32]);

  always_comb begin
    accept_en = (state_q == StRun) && mode_reads(out_q.w_r_mode) &&
                (rd_cnt_q != out_q.rd_target_num);
    spi.s_axis_tready = accept_en & rd_tready[grant_q];
    rd_tvalid = '0;
    if (accept_en) rd_tvalid[grant_q] = spi.s_axis_tvalid;
    rd_tdata = (state_q == StRun) ? spi.s_axis_tdata : 32'd0;
    hs       = spi.s_axis_tvalid & spi.s_axis_tready;
    rd_cnt_d = rd_cnt_q + 16'(hs);
    if (mode_reads(out_q.w_r_mode)) begin
      complete = (spi.spi_done | done_seen_q) && (rd_cnt_d == out_q.rd_target_num);
    end else begin
      complete = spi.spi_done;
    end
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  logic [31:0] wd_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_q       <= CfgPark;
      grant_q     <= '0;
      last_q      <= IdxW'(NUM_REQ - 1);
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      done_seen_q <= 1'b0;
      ready_q     <= '0;
      err_q       <= '0;
      rd_cnt_q    <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      ready_q <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            ready_q[pick_id] <= 1'b1;
            if (pick_cfg.w_r_mode == MODE_BAD) begin
              err_q[pick_id] <= 1'b1;
              last_q         <= pick_id;
            end else begin
              out_q   <= pick_cfg;
              grant_q <= pick_id;
              busy_q  <= 1'b1;
              state_q <= StConfig;
            end
          end
        end
        StConfig: state_q <= StStart;
        StStart: begin
          start_q     <= 1'b1;
          done_seen_q <= 1'b0;
          rd_cnt_q    <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
          wd_q        <= '0;
`endif
          state_q     <= StRun;
        end
        StRun: begin
          if (hs) rd_cnt_q <= rd_cnt_d;
          if (spi.spi_done) done_seen_q <= 1'b1;
`ifdef SPI_SCHED_TIMEOUT_EN
          wd_q <= hs ? 32'd0 : wd_q + 32'd1;
`endif
          if (complete) begin
            out_q   <= CfgPark;
            busy_q  <= 1'b0;
            state_q <= StRelease;
          end
`ifdef SPI_SCHED_TIMEOUT_EN
          else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
            err_q[grant_q] <= 1'b1;
            out_q          <= CfgPark;
            busy_q         <= 1'b0;
            state_q        <= StRelease;
          end
`endif
        end
        StRelease: begin
          last_q  <= grant_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready             = ready_q;
  assign err                   = err_q;
  assign busy                  = busy_q;
  assign grant_id              = 3'(grant_q);
  assign spi.spi_start         = start_q;
  assign spi.spi_cpol          = out_q.cpol;
  assign spi.spi_cpha          = out_q.cpha;
  assign spi.spi_w_r_mode      = out_q.w_r_mode;
  assign spi.spi_wr_width      = out_q.wr_width;
  assign spi.spi_rd_width      = out_q.rd_width;
  assign spi.spi_rd_target_num = out_q.rd_target_num;

endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched with a read-word scoreboard.
module tb_spi_master_sched;
  import spi_pkg::*;

  localparam int unsigned NReq = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NReq-1:0]      req_valid, req_ready, rd_tvalid, rd_tready, err;
  logic [32*NReq-1:0]   req_cfg;
  logic [31:0]          rd_tdata;
  logic [2:0]           grant_id;
  logic                 busy;

  spi_master_sched_if spi_bus ();

  spi_master_sched #(
    .NUM_REQ        (NReq),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cfg   (req_cfg),
    .spi       (spi_bus),
    .rd_tdata  (rd_tdata),
    .rd_tvalid (rd_tvalid),
    .rd_tready (rd_tready),
    .grant_id  (grant_id),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pop   = 0;
  logic [31:0] exp_q[$];
  int          exp_id_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Scoreboard: every requester-side read handshake must match the next queued word.
  always @(negedge clk) begin
    if (rst_n && |(rd_tvalid & rd_tready)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", rd_tdata, 32'hdead_beef);
      end else begin
        check("sb_data", rd_tdata, exp_q.pop_front());
        check("sb_owner", 32'(rd_tvalid), 32'(1) << exp_id_q.pop_front());
        n_pop++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] m, input logic cpol, input logic cpha,
                                     input logic [5:0] wr, input logic [5:0] rd,
                                     input logic [15:0] tgt);
    return {tgt, rd, wr, cpha, cpol, m};
  endfunction

  task automatic request(input int id, input logic [31:0] cfg);
    req_cfg[32*id +: 32] = cfg;
    req_valid[id] = 1'b1;
  endtask

  task automatic pulse_done();
    spi_bus.spi_done = 1'b1;
    step();
    spi_bus.spi_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input int id);
    int n = 0;
    spi_bus.s_axis_tdata  = d;
    spi_bus.s_axis_tvalid = 1'b1;
    exp_q.push_back(d);
    exp_id_q.push_back(id);
    do begin
      @(negedge clk);
      n++;
    end while (!spi_bus.s_axis_tready && n < 50);
    check("hs_within_budget", 32'(n < 50), 32'd1);
    step();
    spi_bus.s_axis_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL tb_watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   k;
    req_valid = '0;
    req_cfg   = '0;
    rd_tready = '0;
    spi_bus.spi_done      = 1'b0;
    spi_bus.s_axis_tdata  = 32'h1234_5678;
    spi_bus.s_axis_tvalid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_w_r_mode", 32'(spi_bus.spi_w_r_mode), 32'(MODE_WR));
    check("rst_rd_target", 32'(spi_bus.spi_rd_target_num), 0);
    check("rst_start", 32'(spi_bus.spi_start), 0);
    check("rst_tready", 32'(spi_bus.s_axis_tready), 0);
    check("rst_rd_tdata", rd_tdata, 0);
    check("rst_err_rd_tvalid", 32'({err, rd_tvalid}), 0);
    step();
    rst_n = 1'b1;
    step();

    // Req0 mode 00, three read words then done
    request(0, mk(MODE_RD, 1'b1, 1'b0, 6'd8, 6'd16, 16'd3));
    @(negedge clk);
    check("a_ready_c0", 32'(req_ready), 0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("a_ready_c1", 32'(req_ready), 32'b0001);
    check("a_busy", 32'(busy), 1);
    check("a_grant", 32'(grant_id), 0);
    check("a_cfg", {16'(spi_bus.spi_rd_target_num), 6'(spi_bus.spi_rd_width), 6'(spi_bus.spi_wr_width),
                    spi_bus.spi_cpha, spi_bus.spi_cpol, spi_bus.spi_w_r_mode},
          mk(MODE_RD, 1'b1, 1'b0, 6'd8, 6'd16, 16'd3));
    check("a_start_c1", 32'(spi_bus.spi_start), 0);
    @(negedge clk);
    check("a_start_c2", 32'(spi_bus.spi_start), 0);
    @(negedge clk);
    check("a_start_c3", 32'(spi_bus.spi_start), 1);
    step();
    rd_tready = 4'b0001;
    send_word(32'hA000_0001, 0);
    send_word(32'hA000_0002, 0);
    send_word(32'hA000_0003, 0);
    check("a_busy_before_done", 32'(busy), 1);
    pulse_done();
    @(negedge clk);
    check("a_busy_released", 32'(busy), 0);
    check("a_parked_mode", 32'(spi_bus.spi_w_r_mode), 32'(MODE_WR));
    check("a_parked_width", 32'(spi_bus.spi_rd_width), 0);
    check("a_words_popped", 32'(n_pop), 3);
    step();
    spi_bus.s_axis_tvalid = 1'b1;
    @(negedge clk);
    check("a_extra_held_off", 32'({spi_bus.s_axis_tready, rd_tvalid}), 0);
    step();
    spi_bus.s_axis_tvalid = 1'b0;

    // Req1 mode 01: start two cycles after ready, stray words never accepted
    request(1, mk(MODE_WR, 1'b0, 1'b1, 6'd24, 6'd0, 16'd0));
    rd_tready = '1;
    spi_bus.s_axis_tvalid = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    seen |= spi_bus.s_axis_tready;
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("c_ready", 32'(req_ready), 32'b0010);
    check("c_grant", 32'(grant_id), 1);
    @(negedge clk);
    seen |= spi_bus.s_axis_tready;
    @(negedge clk);
    check("c_start", 32'(spi_bus.spi_start), 1);
    check("c_cpha", 32'(spi_bus.spi_cpha), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= spi_bus.s_axis_tready;
    end
    step();
    pulse_done();
    @(negedge clk);
    check("c_busy_released", 32'(busy), 0);
    check("c_tready_never", 32'(seen), 0);
    spi_bus.s_axis_tvalid = 1'b0;
    rd_tready = '0;
    step();

    // Req1 and req2 together after last_grant=1: req2 first, req1 back-to-back
    request(1, mk(MODE_RD, 1'b0, 1'b0, 6'd8, 6'd32, 16'd3));
    request(2, mk(MODE_WR, 1'b1, 1'b1, 6'd16, 6'd0, 16'd0));
    @(negedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("b_ready_req2_first", 32'(req_ready), 32'b0100);
    check("b_grant2", 32'(grant_id), 2);
    @(negedge clk);
    @(negedge clk);
    check("b_start2", 32'(spi_bus.spi_start), 1);
    step();
    pulse_done();
    @(negedge clk);
    check("b_release2", 32'(busy), 0);
    @(negedge clk);
    check("b_idle_gap", 32'(req_ready), 0);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("b_ready_req1_next", 32'(req_ready), 32'b0010);
    check("b_grant1", 32'(grant_id), 1);
    @(negedge clk);
    check("b_no_early_start", 32'(spi_bus.spi_start), 0);
    @(negedge clk);
    check("b_start1", 32'(spi_bus.spi_start), 1);

    // Done before the last word, requester stalls five cycles
    step();
    pulse_done();
    spi_bus.s_axis_tdata  = 32'hB000_0001;
    spi_bus.s_axis_tvalid = 1'b1;
    rd_tready = '0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen |= spi_bus.s_axis_tready | ~busy;
    end
    check("e_stall_holds", 32'(seen), 0);
    step();
    rd_tready = 4'b0010;
    send_word(32'hB000_0001, 1);
    send_word(32'hB000_0002, 1);
    @(negedge clk);
    check("e_busy_after_two", 32'(busy), 1);
    step();
    send_word(32'hB000_0003, 1);
    @(negedge clk);
    check("e_busy_after_third", 32'(busy), 0);
    check("e_words_popped", 32'(n_pop), 6);
    rd_tready = '0;
    step();

    // Mode 11 on req3: error with accept, no transaction
    request(3, mk(MODE_BAD, 1'b0, 1'b0, 6'd8, 6'd8, 16'd1));
    @(negedge clk);
    @(negedge clk);
    req_valid[3] = 1'b0;
    check("d_ready3", 32'(req_ready), 32'b1000);
    check("d_err3", 32'(err), 32'b1000);
    check("d_not_busy", 32'(busy), 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen |= spi_bus.spi_start | busy | (|err);
    end
    check("d_no_txn", 32'(seen), 0);
    step();

    // Pointer advanced to 3: req0 beats req2
    request(0, mk(MODE_WR, 1'b0, 1'b0, 6'd8, 6'd0, 16'd0));
    request(2, mk(MODE_WR, 1'b0, 1'b0, 6'd8, 6'd0, 16'd0));
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    check("f_ready0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    @(negedge clk);
    step();
    pulse_done();
    @(negedge clk);
    check("f_released", 32'(busy), 0);
    step();

    // Asynchronous reset mid-RUN
    request(0, mk(MODE_RD, 1'b1, 1'b1, 6'd8, 6'd8, 16'd2));
    rd_tready = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    step();
    spi_bus.s_axis_tvalid = 1'b1;
    exp_q.push_back(spi_bus.s_axis_tdata);
    exp_id_q.push_back(0);
    @(negedge clk);
    check("g_tready_pre_reset", 32'(spi_bus.s_axis_tready), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("g_rst_busy", 32'(busy), 0);
    check("g_rst_tready", 32'(spi_bus.s_axis_tready), 0);
    check("g_rst_mode", 32'(spi_bus.spi_w_r_mode), 32'(MODE_WR));
    check("g_rst_cpol", 32'({spi_bus.spi_cpol, spi_bus.spi_cpha}), 0);
    check("g_rst_rdata", rd_tdata, 0);
    spi_bus.s_axis_tvalid = 1'b0;
    rd_tready = '0;
    step();
    rst_n = 1'b1;
    step();

`ifdef SPI_SCHED_TIMEOUT_EN
    // Watchdog: no done, no words
    request(0, mk(MODE_RD, 1'b0, 1'b0, 6'd8, 6'd8, 16'd1));
    @(negedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t_start", 32'(spi_bus.spi_start), 1);
    k = 1;
    while (!err[0] && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("t_err_cycle", 32'(k), 101);
    check("t_busy_dropped", 32'(busy), 0);
    step();
`else
    k = 0;
`endif

    check("z_scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
